// File: rtl/block_pkg.sv
// Shared types and helpers for the falling-block spawner.
package block_pkg;

  localparam int NUM_SLOTS = 5;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [9:0] coord_t;
  typedef logic [NUM_SLOTS-1:0] slot_mask_t;

  typedef enum logic [1:0] {
    IDLE,
    MOVE,
    COMPACT,
    SPAWN
  } spawn_state_t;

  function automatic slot_mask_t live_mask(input logic [2:0] n);
    live_mask = NUM_SLOTS'((6'd1 << n) - 6'd1);
  endfunction

  function automatic logic [2:0] lowest_set(input slot_mask_t m);
    lowest_set = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1.
// Shifts left every clock; the feedback enters at bit 0.
module lfsr16
  import block_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
  assign q      = lfsr_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) lfsr_q <= seed;
    else          lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/block_spawner.sv
// Falling target blocks for the colour mapper: move, compact, spawn once per frame.
// Define BLOCK_SPEEDUP_EN to raise the fall step after every 8th spawn.
module block_spawner
  import block_pkg::*;
#(
  parameter int          MAX_ACTIVE   = 2,
  parameter int          SPAWN_FRAMES = 60,
  parameter int          FALL_STEP    = 1,
  parameter int          BLOCK_SIZE   = 8,
  parameter int          X_MIN        = 16,
  parameter int          X_MAX        = 623,
  parameter int          Y_START      = 0,
  parameter int          Y_MAX        = 479,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [4:0] hit,
  output logic [9:0] BlockX     [NUM_SLOTS],
  output logic [9:0] BlockY     [NUM_SLOTS],
  output logic [9:0] Block_size [NUM_SLOTS],
  output logic [2:0] block_ready,
  output logic       missed
);

  localparam int          CW      = $clog2(SPAWN_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SPAWN_FRAMES);
  localparam coord_t      X_LO    = coord_t'(X_MIN);
  localparam coord_t      X_HI    = coord_t'(X_MAX - BLOCK_SIZE);
  localparam logic [10:0] Y_LIM   = 11'(Y_MAX - BLOCK_SIZE);
  localparam logic [2:0]  CAP     = 3'(MAX_ACTIVE);

  spawn_state_t  state_q, state_d;
  coord_t        x_q [NUM_SLOTS];
  coord_t        x_d [NUM_SLOTS];
  coord_t        y_q [NUM_SLOTS];
  coord_t        y_d [NUM_SLOTS];
  logic [2:0]    br_q, br_d;
  slot_mask_t    m_q, m_d, m_or, live;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic          missed_q, missed_d;
  logic [2:0]    sync_q;
  logic          tick;
  logic [15:0]   lfsr;
  coord_t        c, step;
  logic [2:0]    k;
  logic          unused_lfsr;

  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .seed    (LFSR_SEED),
    .q       (lfsr)
  );

  assign c           = lfsr[9:0];
  assign unused_lfsr = ^lfsr[15:10];
  assign tick        = sync_q[1] & ~sync_q[2];
  assign live        = live_mask(br_q);
  assign m_or        = (m_q | hit) & live;
  assign k           = lowest_set(m_or);

`ifdef BLOCK_SPEEDUP_EN
  localparam coord_t STEP_MAX = coord_t'(FALL_STEP + 3);
  coord_t     step_q, step_d;
  logic [2:0] scnt_q, scnt_d;
  assign step = step_q;
`else
  assign step = coord_t'(FALL_STEP);
`endif

  // sync_q[1:0] resynchronise vsync; sync_q[2] is the edge-detect history
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], frame_clk};
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    br_d     = br_q;
    m_d      = m_or;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q | (tick & (state_q != IDLE));
    missed_d = 1'b0;
`ifdef BLOCK_SPEEDUP_EN
    step_d   = step_q;
    scnt_d   = scnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d = MOVE;
          pend_d  = 1'b0;
        end
      end
      MOVE: begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (live[i]) begin
            if ({1'b0, y_q[i]} + {1'b0, step} > Y_LIM) begin
              m_d[i]   = 1'b1;
              missed_d = 1'b1;
            end else begin
              y_d[i] = y_q[i] + step;
            end
          end
        end
        if (fcnt_q < CNT_MAX) fcnt_d = fcnt_q + 1'b1;
        state_d = COMPACT;
      end
      COMPACT: begin
        if (m_or == '0) begin
          state_d = SPAWN;
        end else begin
          for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if (3'(i) >= k) begin
              x_d[i] = x_q[i+1];
              y_d[i] = y_q[i+1];
              m_d[i] = m_or[i+1];
            end
          end
          m_d[NUM_SLOTS-1] = 1'b0;
          br_d = br_q - 1'b1;
        end
      end
      SPAWN: begin
        if (fcnt_q < CNT_MAX || br_q == CAP) begin
          state_d = IDLE;
        end else if (c >= X_LO && c <= X_HI) begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (3'(i) == br_q) begin
              x_d[i] = c;
              y_d[i] = coord_t'(Y_START);
            end
          end
          br_d    = br_q + 1'b1;
          fcnt_d  = '0;
          state_d = IDLE;
`ifdef BLOCK_SPEEDUP_EN
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == 3'd7 && step_q < STEP_MAX) step_d = step_q + 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      br_q     <= '0;
      m_q      <= '0;
      fcnt_q   <= '0;
      pend_q   <= 1'b0;
      missed_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      br_q     <= br_d;
      m_q      <= m_d;
      fcnt_q   <= fcnt_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
      x_q      <= x_d;
      y_q      <= y_d;
    end
  end

`ifdef BLOCK_SPEEDUP_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      step_q <= coord_t'(FALL_STEP);
      scnt_q <= '0;
    end else begin
      step_q <= step_d;
      scnt_q <= scnt_d;
    end
  end
`endif

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_size
    assign Block_size[g] = coord_t'(BLOCK_SIZE);
  end

  assign BlockX      = x_q;
  assign BlockY      = y_q;
  assign block_ready = br_q;
  assign missed      = missed_q;

endmodule
